// File: rtl/mem_stage_bridge.sv
// Memory-stage bridge: turns the core's M-stage load/store into a single
// ready/valid bus transaction. It holds the pipeline until the access retires
// and returns aligned, sign- or zero-extended load data.
// Optional feature macro: ALIGN_CHECK_EN. When it is defined, misaligned accesses
// are trapped and reported on adelM/adesM instead of being issued on the bus.
module mem_stage_bridge #(
    parameter int ADDR_W = 32,
    parameter int SIZE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memreadM,
    input  logic              memwriteM,
    input  logic [SIZE_W-1:0] sizeM,
    input  logic              signedM,
    input  logic [ADDR_W-1:0] aluoutM,
    input  logic [31:0]       writedataM,
    output logic [31:0]       readdataM,
    output logic              stallM,
    output logic              adelM,
    output logic              adesM,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic              op;
    logic              bad;
    logic [ADDR_W-1:0] addr_q;
    logic [SIZE_W-1:0] size_q;
    logic              sign_q;
    logic              we_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;

    // Byte-lane enables for a store of the given size at the given offset.
    function automatic logic [3:0] lane_strobe(input logic [SIZE_W-1:0] sz,
                                               input logic [1:0] a);
        if (sz == SIZE_W'(0))
            return 4'b0001 << a;
        else if (sz == SIZE_W'(1))
            return a[1] ? 4'b1100 : 4'b0011;
        else
            return 4'b1111;
    endfunction

    // Replicates the right-justified store data across every lane it may occupy.
    function automatic logic [31:0] lane_wdata(input logic [SIZE_W-1:0] sz,
                                               input logic [31:0] d);
        if (sz == SIZE_W'(0))
            return {4{d[7:0]}};
        else if (sz == SIZE_W'(1))
            return {2{d[15:0]}};
        else
            return d;
    endfunction

    // Selects the addressed byte or half from the bus word and extends it.
    function automatic logic [31:0] load_extract(input logic [SIZE_W-1:0] sz,
                                                 input logic sgn,
                                                 input logic [1:0] a,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{a, 3'b000} +: 8];
        h = rd[{a[1], 4'b0000} +: 16];
        if (sz == SIZE_W'(0))
            return {{24{sgn & b[7]}}, b};
        else if (sz == SIZE_W'(1))
            return {{16{sgn & h[15]}}, h};
        else
            return rd;
    endfunction

`ifdef ALIGN_CHECK_EN
    // A half must sit on an even byte and a word on a 4-byte boundary.
    function automatic logic misaligned(input logic [SIZE_W-1:0] sz,
                                        input logic [1:0] a);
        if (sz == SIZE_W'(0))
            return 1'b0;
        else if (sz == SIZE_W'(1))
            return a[0];
        else
            return a != 2'b00;
    endfunction

    assign bad = misaligned(sizeM, aluoutM[1:0]);
`else
    assign bad = 1'b0;
`endif

    assign op = memreadM | memwriteM;

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state, bus request and pipeline stall.
    always_comb begin
        state_nxt = state;
        stallM    = 1'b0;
        bus_req   = 1'b0;
        case (state)
            S_IDLE: begin
                if (op) begin
                    stallM    = 1'b1;
                    state_nxt = bad ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                stallM  = 1'b1;
                bus_req = 1'b1;
                if (bus_gnt)
                    state_nxt = we_q ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                stallM = 1'b1;
                if (bus_rvalid)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Captures the access fields when a new op is accepted in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            wstrb_q <= 4'b0000;
            wdata_q <= 32'h0;
        end else if (state == S_IDLE && op) begin
            addr_q  <= aluoutM;
            size_q  <= sizeM;
            sign_q  <= signedM;
            we_q    <= memwriteM;
            wstrb_q <= memwriteM ? lane_strobe(sizeM, aluoutM[1:0]) : 4'b0000;
            wdata_q <= memwriteM ? lane_wdata(sizeM, writedataM) : 32'h0;
        end
    end

    // Load result register; only updated by read data that arrives in WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            readdataM <= 32'h0;
        else if (state == S_WAIT && bus_rvalid)
            readdataM <= load_extract(size_q, sign_q, addr_q[1:0], bus_rdata);
    end

    assign bus_we    = we_q;
    assign bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus_wstrb = wstrb_q;
    assign bus_wdata = wdata_q;

`ifdef ALIGN_CHECK_EN
    logic err_q;

    // Remembers whether the accepted access was trapped as misaligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_q <= 1'b0;
        else if (state == S_IDLE && op)
            err_q <= bad;
    end

    assign adelM = (state == S_DONE) & err_q & ~we_q;
    assign adesM = (state == S_DONE) & err_q & we_q;
`else
    assign adelM = 1'b0;
    assign adesM = 1'b0;
`endif

endmodule
